hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//  Event generator that drives the combo counter's miss / non_full_clear_hit / full_clear_hit inputs.
//  Tracks the set of live moles and a per-hole lifetime timer, and samples the player's hole buttons.
//  Judges every press and every timer expiry, then emits exactly one registered single-cycle event per cycle.
//  Sits between the mole spawner / button front-end and the combo/score logic.
// PARAMETERS
//  N_MOLES    8          number of holes; width of every per-hole vector
//  LIFE_W     26         width of each lifetime counter
//  MOLE_LIFE  50000000   cycles a mole stays up before it counts as a miss (1 s at 50 MHz); 1..2^LIFE_W-1
// PORTS
//  clk                 in   1        system clock, 50 MHz
//  rst_n               in   1        asynchronous active-low reset
//  enable              in   1        game running; low = board cleared, inputs ignored
//  spawn               in   N_MOLES  one-cycle pulse per hole: raise a mole there
//  button              in   N_MOLES  player hole buttons, active high
//  mole_active         out  N_MOLES  current live-mole mask (registered)
//  miss                out  1        1-cycle pulse: wrong hole hit or mole expired
//  non_full_clear_hit  out  1        1-cycle pulse: mole hit, other moles remain
//  full_clear_hit      out  1        1-cycle pulse: the hit emptied the board
// BEHAVIOUR
//  Reset (async, rst_n=0): mole_active=0, all timers=0, miss=non_full_clear_hit=full_clear_hit=0, edge regs=0.
//  press[i] = rising edge of the (conditioned) button[i]: button[i]=1 now and 0 in the previous sample.
//  Per cycle, with enable=1, evaluation uses the board state B = mole_active before this cycle's update:
//   hit   = press & B
//   wrong = press & ~B
//   exp   = B & (timer==1); a timer decrements only while its mole is live
//   B_next = ((B & ~hit & ~exp) | spawn)
//   A spawned hole loads its timer with MOLE_LIFE; a spawn on a live hole reloads its timer.
//   Event outputs, registered, valid the cycle after the press edge:
//    wrong!=0 or exp!=0                -> miss=1 (miss dominates; hits in the same cycle still clear)
//    else hit!=0 and (B&~hit)==0       -> full_clear_hit=1 (same-cycle spawns are ignored for this test)
//    else hit!=0                       -> non_full_clear_hit=1
//    else                              -> all events 0
//   At most one event output is high in any cycle; every event is exactly one cycle wide.
//   Several correct hits in one cycle produce a single event, never multiple pulses.
//  Boundary rules:
//   spawn and hit on the same hole, same cycle: the hit is judged against B; the mole stays up with a fresh timer.
//   spawn and expiry on the same hole, same cycle: miss=1; the mole stays up with a fresh timer.
//   A held button produces one press only; release followed by re-press produces a new press.
//  enable=0: mole_active and timers are cleared next cycle; all events forced to 0; spawn and button are ignored.
//   Edge registers keep sampling, so a button held across enable rising produces no press.
//  rst_n asserted mid-game: everything clears immediately; no event pulse is produced on release.
// CONFIGURATION
//  BUTTON_SYNC_EN defined:
//   button passes through a 2-flop synchroniser before edge detection.
//   Press-to-event latency is 3 clk edges from the first sample.
//  BUTTON_SYNC_EN undefined:
//   button must already be synchronous to clk and is edge-detected directly.
//   Press-to-event latency is 1 clk edge after the edge-detect sample.
//  Judging logic is identical in both builds.
// TESTING (N_MOLES=4, MOLE_LIFE=10; latencies quoted with BUTTON_SYNC_EN undefined)
//  1. Full clear: rst_n low -> all outputs 0; spawn=4'b0011.
//     Press hole 0 -> non_full_clear_hit for 1 cycle, mole_active=4'b0010.
//     Then press hole 1 -> full_clear_hit for 1 cycle, mole_active=0.
//  2. Wrong hole: board 4'b0001, press hole 2 -> miss=1 for 1 cycle, mole_active stays 4'b0001.
//  3. Expiry: spawn=4'b0100, no presses -> miss pulses 10 cycles after the spawn; mole_active becomes 0.
//  4. Simultaneous press: board 4'b0011, press holes 0 and 2 in one cycle.
//     -> miss=1 only (no hit pulse); mole_active=4'b0010.
//  5. Held button: board 4'b0011, hold hole 0 high for 20 cycles.
//     -> exactly one non_full_clear_hit; no further events until the expiry miss for hole 1.
//  6. Reset / enable: board 4'b1111, then drop enable or rst_n mid-game.
//     -> mole_active=0, no event pulses, and later presses are ignored until enable=1.

Source files
------------

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - judges player presses and mole expiry into miss / partial-hit / full-clear pulses
// Optional BUTTON_SYNC_EN: 2-flop button synchroniser ahead of edge detection.
module hit_judge #(
   parameter int N_MOLES   = 8,
   parameter int LIFE_W    = 26,
   parameter int MOLE_LIFE = 50000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [N_MOLES-1:0] spawn,
   input  logic [N_MOLES-1:0] button,
   output logic [N_MOLES-1:0] mole_active,
   output logic               miss,
   output logic               non_full_clear_hit,
   output logic               full_clear_hit
);

   localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(MOLE_LIFE);
   localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);

   logic [N_MOLES-1:0] btn_c;
   logic [N_MOLES-1:0] btn_prev;
   logic [N_MOLES-1:0] press;
   logic [N_MOLES-1:0] hit;
   logic [N_MOLES-1:0] wrong;
   logic [N_MOLES-1:0] expire;
   logic [N_MOLES-1:0] remain;
   logic [N_MOLES-1:0] board_next;
   logic [LIFE_W-1:0]  timer [N_MOLES];
   logic               miss_next;
   logic               full_next;
   logic               partial_next;

`ifdef BUTTON_SYNC_EN
   logic [N_MOLES-1:0] sync1;
   logic [N_MOLES-1:0] sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   assign btn_c = sync2;
`else
   assign btn_c = button;
`endif

   // Edge register samples even while disabled so a held button never fires on enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_prev <= '0;
      else        btn_prev <= btn_c;
   end

   assign press = btn_c & ~btn_prev;

   always_comb begin
      hit    = press & mole_active;
      wrong  = press & ~mole_active;
      expire = '0;
      for (int i = 0; i < N_MOLES; i++)
         expire[i] = mole_active[i] && (timer[i] == LIFE_ONE);
      remain       = mole_active & ~hit;
      board_next   = (mole_active & ~hit & ~expire) | spawn;
      miss_next    = (|wrong) || (|expire);
      full_next    = !miss_next && (|hit) && !(|remain);
      partial_next = !miss_next && (|hit) && (|remain);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mole_active        <= '0;
         miss               <= 1'b0;
         non_full_clear_hit <= 1'b0;
         full_clear_hit     <= 1'b0;
         for (int i = 0; i < N_MOLES; i++) timer[i] <= '0;
      end else if (!enable) begin
         mole_active        <= '0;
         miss               <= 1'b0;
         non_full_clear_hit <= 1'b0;
         full_clear_hit     <= 1'b0;
         for (int i = 0; i < N_MOLES; i++) timer[i] <= '0;
      end else begin
         mole_active        <= board_next;
         miss               <= miss_next;
         non_full_clear_hit <= partial_next;
         full_clear_hit     <= full_next;
         // Spawn wins over hit/expiry on the same hole: the mole stays with a fresh timer.
         for (int i = 0; i < N_MOLES; i++) begin
            if (spawn[i])
               timer[i] <= LIFE_INIT;
            else if (!board_next[i])
               timer[i] <= '0;
            else
               timer[i] <= timer[i] - LIFE_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - directed self-checking bench for hit_judge (N_MOLES=4, MOLE_LIFE=10)
module tb_hit_judge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] spawn;
   logic [3:0] button;
   logic [3:0] mole_active;
   logic       miss;
   logic       non_full_clear_hit;
   logic       full_clear_hit;

   int vectors    = 0;
   int miscompares = 0;

   hit_judge #(.N_MOLES(4), .LIFE_W(26), .MOLE_LIFE(10)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .enable             (enable),
      .spawn              (spawn),
      .button             (button),
      .mole_active        (mole_active),
      .miss               (miss),
      .non_full_clear_hit (non_full_clear_hit),
      .full_clear_hit     (full_clear_hit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Events packed as {0, miss, non_full_clear_hit, full_clear_hit}.
   function automatic logic [3:0] ev();
      return {1'b0, miss, non_full_clear_hit, full_clear_hit};
   endfunction

   initial begin
      int n_miss;
      int n_hit;
      int miss_k;

      rst_n = 1'b0; enable = 1'b0; spawn = '0; button = '0;
      tick(); tick();
      chk("reset_mask", mole_active, 4'b0000);
      chk("reset_events", ev(), 4'b0000);
      rst_n = 1'b1; enable = 1'b1;
      tick();
      chk("idle_events", ev(), 4'b0000);

      // 1. full clear
      spawn = 4'b0011; tick(); spawn = '0;
      chk("t1_spawn_mask", mole_active, 4'b0011);
      button = 4'b0001; tick();
      chk("t1_partial_ev", ev(), 4'b0010);
      chk("t1_partial_mask", mole_active, 4'b0010);
      button = '0; tick();
      chk("t1_partial_1cyc", ev(), 4'b0000);
      button = 4'b0010; tick();
      chk("t1_full_ev", ev(), 4'b0001);
      chk("t1_full_mask", mole_active, 4'b0000);
      button = '0; tick();
      chk("t1_full_1cyc", ev(), 4'b0000);

      // 2. wrong hole
      spawn = 4'b0001; tick(); spawn = '0;
      button = 4'b0100; tick();
      chk("t2_miss_ev", ev(), 4'b0100);
      chk("t2_mask", mole_active, 4'b0001);
      button = '0; tick();
      chk("t2_miss_1cyc", ev(), 4'b0000);
      button = 4'b0001; tick();
      chk("t2_clear_ev", ev(), 4'b0001);
      button = '0; tick();

      // 3. expiry 10 cycles after spawn
      spawn = 4'b0100; tick(); spawn = '0;
      n_miss = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (ev() != 4'b0000) n_miss++;
      end
      chk_int("t3_no_early_event", n_miss, 0);
      chk("t3_mask_live", mole_active, 4'b0100);
      tick();
      chk("t3_expiry_ev", ev(), 4'b0100);
      chk("t3_expiry_mask", mole_active, 4'b0000);
      tick();
      chk("t3_expiry_1cyc", ev(), 4'b0000);

      // 4. correct and wrong press together
      spawn = 4'b0011; tick(); spawn = '0;
      button = 4'b0101; tick();
      chk("t4_miss_only", ev(), 4'b0100);
      chk("t4_mask", mole_active, 4'b0010);
      button = '0; tick();
      button = 4'b0010; tick();
      chk("t4_clear_ev", ev(), 4'b0001);
      button = '0; tick();

      // 5. held button, then hole 1 expires 10 cycles after spawn
      spawn = 4'b0011; tick(); spawn = '0;
      button = 4'b0001; tick();
      chk("t5_first_hit", ev(), 4'b0010);
      n_miss = 0; n_hit = 0; miss_k = -1;
      for (int k = 2; k <= 20; k++) begin
         tick();
         if (miss) begin n_miss++; miss_k = k; end
         if (non_full_clear_hit || full_clear_hit) n_hit++;
      end
      chk_int("t5_hold_hits", n_hit, 0);
      chk_int("t5_hold_misses", n_miss, 1);
      chk_int("t5_miss_cycle", miss_k, 10);
      chk("t5_mask", mole_active, 4'b0000);
      button = '0; tick();
      spawn = 4'b0001; tick(); spawn = '0;
      button = 4'b0001; tick();
      chk("t5_repress", ev(), 4'b0001);
      button = '0; tick();

      // 5b. spawn and hit on the same hole: judged against old board, mole stays
      spawn = 4'b1001; tick(); spawn = '0;
      spawn = 4'b1000; button = 4'b1000; tick(); spawn = '0; button = '0;
      chk("t5b_ev", ev(), 4'b0010);
      chk("t5b_mask", mole_active, 4'b1001);
      enable = 1'b0; tick(); enable = 1'b1;

      // 6. enable drop
      spawn = 4'b1111; tick(); spawn = '0;
      chk("t6_board_full", mole_active, 4'b1111);
      enable = 1'b0; tick();
      chk("t6_dis_mask", mole_active, 4'b0000);
      chk("t6_dis_ev", ev(), 4'b0000);
      button = 4'b0001; spawn = 4'b0010; tick(); spawn = '0;
      chk("t6_dis_ignored_ev", ev(), 4'b0000);
      chk("t6_dis_ignored_mask", mole_active, 4'b0000);
      enable = 1'b1; tick();
      chk("t6_held_across_enable", ev(), 4'b0000);
      button = '0; tick();

      // 6b. reset mid-game clears asynchronously
      spawn = 4'b1111; tick(); spawn = '0;
      rst_n = 1'b0; #1;
      chk("t6_rst_async_mask", mole_active, 4'b0000);
      button = 4'b0001; tick();
      chk("t6_rst_ev", ev(), 4'b0000);
      rst_n = 1'b1; button = '0; tick();
      chk("t6_rst_release_ev", ev(), 4'b0000);
      chk("t6_rst_release_mask", mole_active, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
